// File: rtl/term_text_buffer_if.sv
// rtl/term_text_buffer_if.sv - character stream, display read port, cursor and captured-line stream of term_text_buffer
interface term_text_buffer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_src;
  logic [7:0] rd_col;
  logic [7:0] rd_row;
  logic [7:0] rd_char;
  logic       rd_cursor;
  logic [7:0] cur_col;
  logic [7:0] cur_row;
  logic       line_valid;
  logic       line_ready;
  logic [7:0] line_data;
  logic       line_last;

  modport master (
    output in_valid, in_data, in_src, rd_col, rd_row, line_ready,
    input  in_ready, rd_char, rd_cursor, cur_col, cur_row, line_valid, line_data, line_last
  );

  modport slave (
    input  in_valid, in_data, in_src, rd_col, rd_row, line_ready,
    output in_ready, rd_char, rd_cursor, cur_col, cur_row, line_valid, line_data, line_last
  );
endinterface

// File: rtl/term_text_buffer.sv
// rtl/term_text_buffer.sv - COLS x ROWS text cell store with circular-top scrolling and blinking cursor read port
// Define LINE_CAPTURE_EN to capture keyboard lines and stream them out on newline.
module term_text_buffer #(
  parameter int COLS       = 70,
  parameter int ROWS       = 30,
  parameter int LINE_MAX   = 32,
  parameter int BLINK_LOG2 = 24
) (
  input logic           clk,
  input logic           rst_n,
  term_text_buffer_if.slave bus
);
  typedef enum logic [1:0] {S_CLR_ALL, S_IDLE, S_CLR_ROW, S_CAP_OUT} state_t;

  localparam int              CELLS    = COLS * ROWS;
  localparam int              AW       = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [7:0]      COLS_M1  = 8'(COLS - 1);
  localparam logic [7:0]      ROWS_M1  = 8'(ROWS - 1);
  localparam logic [15:0]     CELLS_M1 = 16'(CELLS - 1);

  logic [7:0]            mem [CELLS];
  state_t                state_q, state_d;
  logic [7:0]            top_q, top_d, col_q, col_d, row_q, row_d;
  logic [15:0]           clr_q, clr_d;
  logic [BLINK_LOG2-1:0] blink_q, blink_d;
  logic [7:0]            rd_char_q, rd_char_d;
  logic                  rd_cursor_q, rd_cursor_d;
  logic                  mem_we;
  logic [15:0]           mem_waddr, cur_addr, rd_addr;
  logic [7:0]            mem_wdata, bottom_row;
  logic                  do_nl;
  logic                  line_valid, line_last;
  logic [7:0]            line_data;

  function automatic logic [7:0] phys_row(input logic [7:0] top, input logic [7:0] row);
    logic [8:0] sum;
    sum = {1'b0, top} + {1'b0, row};
    if (sum >= 9'(ROWS)) sum = sum - 9'(ROWS);
    return sum[7:0];
  endfunction

  function automatic logic [15:0] cell_addr(input logic [7:0] prow, input logic [7:0] col);
    return 16'(prow) * 16'(COLS) + 16'(col);
  endfunction

`ifdef LINE_CAPTURE_EN
  localparam int         LW        = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam logic [7:0] LINE_MAX8 = 8'(LINE_MAX);

  logic [7:0] cap_mem [LINE_MAX];
  logic [7:0] len_q, len_d, idx_q, idx_d;
  logic       scroll_q, scroll_d;
  logic       cap_we, cap_nl;
`else
  wire unused_cap = &{1'b0, bus.in_src, bus.line_ready, 8'(LINE_MAX)};
`endif

  // The bottom screen row after a scroll is the physical row just above the new top.
  assign bottom_row = (top_q == 8'd0) ? ROWS_M1 : top_q - 8'd1;
  assign cur_addr   = cell_addr(phys_row(top_q, row_q), col_q);
  assign rd_addr    = cell_addr(phys_row(top_q, bus.rd_row), bus.rd_col);

  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    col_d     = col_q;
    row_d     = row_q;
    clr_d     = clr_q;
    blink_d   = blink_q + BLINK_LOG2'(1);
    mem_we    = 1'b0;
    mem_waddr = 16'd0;
    mem_wdata = 8'h00;
    do_nl     = 1'b0;
    line_valid = 1'b0;
    line_data  = 8'h00;
    line_last  = 1'b0;
`ifdef LINE_CAPTURE_EN
    len_d    = len_q;
    idx_d    = idx_q;
    scroll_d = scroll_q;
    cap_we   = 1'b0;
    cap_nl   = 1'b0;
`endif
    rd_char_d   = mem[rd_addr[AW-1:0]];
    rd_cursor_d = blink_q[BLINK_LOG2-1] && (bus.rd_col == col_q) && (bus.rd_row == row_q);

    case (state_q)
      S_CLR_ALL: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        if (clr_q == CELLS_M1) begin
          clr_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          clr_d = clr_q + 16'd1;
        end
      end
      S_CLR_ROW: begin
        mem_we    = 1'b1;
        mem_waddr = cell_addr(bottom_row, clr_q[7:0]);
        if (clr_q[7:0] == COLS_M1) begin
          clr_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          clr_d = clr_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
            mem_we    = 1'b1;
            mem_waddr = cur_addr;
            mem_wdata = bus.in_data;
            if (col_q == COLS_M1) do_nl = 1'b1;
            else                  col_d = col_q + 8'd1;
`ifdef LINE_CAPTURE_EN
            if (bus.in_src && len_q < LINE_MAX8) begin
              cap_we = 1'b1;
              len_d  = len_q + 8'd1;
            end
`endif
          end else begin
            case (bus.in_data)
              8'h0A: begin
                do_nl = 1'b1;
`ifdef LINE_CAPTURE_EN
                cap_nl = bus.in_src;
`endif
              end
              8'h0D: col_d = 8'd0;
              8'h08: begin
                if (col_q != 8'd0) begin
                  col_d     = col_q - 8'd1;
                  mem_we    = 1'b1;
                  mem_waddr = cur_addr - 16'd1;
`ifdef LINE_CAPTURE_EN
                  if (bus.in_src && len_q != 8'd0) len_d = len_q - 8'd1;
`endif
                end
              end
              8'h0C: begin
                top_d   = 8'd0;
                col_d   = 8'd0;
                row_d   = 8'd0;
                clr_d   = 16'd0;
                state_d = S_CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      S_CAP_OUT: begin
`ifdef LINE_CAPTURE_EN
        line_valid = 1'b1;
        line_last  = (len_q == 8'd0) || (idx_q == len_q - 8'd1);
        line_data  = (len_q == 8'd0) ? 8'h00 : cap_mem[idx_q[LW-1:0]];
        if (bus.line_ready) begin
          if (line_last) begin
            len_d   = 8'd0;
            idx_d   = 8'd0;
            state_d = scroll_q ? S_CLR_ROW : S_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_CLR_ALL;
    endcase

    if (do_nl) begin
      col_d = 8'd0;
      if (row_q != ROWS_M1) begin
        row_d = row_q + 8'd1;
      end else begin
        top_d   = (top_q == ROWS_M1) ? 8'd0 : top_q + 8'd1;
        clr_d   = 16'd0;
        state_d = S_CLR_ROW;
      end
    end

`ifdef LINE_CAPTURE_EN
    // The row clear a newline may have requested is deferred until the line has drained.
    if (cap_nl) begin
      scroll_d = (state_d == S_CLR_ROW);
      state_d  = S_CAP_OUT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_CLR_ALL;
      top_q       <= 8'd0;
      col_q       <= 8'd0;
      row_q       <= 8'd0;
      clr_q       <= 16'd0;
      blink_q     <= '0;
      rd_char_q   <= 8'h00;
      rd_cursor_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      top_q       <= top_d;
      col_q       <= col_d;
      row_q       <= row_d;
      clr_q       <= clr_d;
      blink_q     <= blink_d;
      rd_char_q   <= rd_char_d;
      rd_cursor_q <= rd_cursor_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr[AW-1:0]] <= mem_wdata;
  end

`ifdef LINE_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q    <= 8'd0;
      idx_q    <= 8'd0;
      scroll_q <= 1'b0;
    end else begin
      len_q    <= len_d;
      idx_q    <= idx_d;
      scroll_q <= scroll_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && cap_we) cap_mem[len_q[LW-1:0]] <= bus.in_data;
  end
`endif

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.rd_char    = rd_char_q;
  assign bus.rd_cursor  = rd_cursor_q;
  assign bus.cur_col    = col_q;
  assign bus.cur_row    = row_q;
  assign bus.line_valid = line_valid;
  assign bus.line_data  = line_data;
  assign bus.line_last  = line_last;
endmodule

// File: tb/tb_term_text_buffer.sv
// tb/tb_term_text_buffer.sv - directed, table-driven bench for term_text_buffer (70x30, fast blink)
module tb_term_text_buffer;
  localparam int COLS = 70;
  localparam int ROWS = 30;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] col;
    logic [7:0] row;
  } cur_vec_t;

  typedef struct {
    logic [7:0] col;
    logic [7:0] row;
    logic [7:0] val;
  } cell_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  term_text_buffer_if bus ();

  term_text_buffer #(
    .COLS(COLS), .ROWS(ROWS), .LINE_MAX(32), .BLINK_LOG2(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  cur_vec_t   cv [12];
  cell_vec_t  ce [7];
  logic [7:0] bd [4];
  logic       bl [4];
  int         nb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ch, input logic src);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = ch;
    bus.in_src   = src;
    while (!bus.in_ready && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 5000 cycles");
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic read_cell(input int col, input int row, output logic [7:0] v);
    bus.rd_col = 8'(col);
    bus.rd_row = 8'(row);
    tick();
    v = bus.rd_char;
  endtask

  task automatic wait_ready(input int max, output int cnt);
    cnt = 0;
    while (!bus.in_ready && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  task automatic collect();
    nb = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.line_ready = cyc[0];
      #2;
      if (bus.line_valid && bus.line_ready && nb < 4) begin
        bd[nb] = bus.line_data;
        bl[nb] = bus.line_last;
        nb++;
      end
      tick();
      if (nb > 0 && bl[nb-1]) break;
    end
    bus.line_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before 1000000 time units");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0] v;
    int cnt, nz, ones;

    cv[0]  = '{8'h41, 8'd1, 8'd0};
    cv[1]  = '{8'h42, 8'd2, 8'd0};
    cv[2]  = '{8'h07, 8'd2, 8'd0};
    cv[3]  = '{8'h0A, 8'd0, 8'd1};
    cv[4]  = '{8'h78, 8'd1, 8'd1};
    cv[5]  = '{8'h79, 8'd2, 8'd1};
    cv[6]  = '{8'h7A, 8'd3, 8'd1};
    cv[7]  = '{8'h08, 8'd2, 8'd1};
    cv[8]  = '{8'h0D, 8'd0, 8'd1};
    cv[9]  = '{8'h08, 8'd0, 8'd1};
    cv[10] = '{8'h7F, 8'd0, 8'd1};
    cv[11] = '{8'h1F, 8'd0, 8'd1};

    ce[0] = '{8'd0, 8'd0, 8'h41};
    ce[1] = '{8'd1, 8'd0, 8'h42};
    ce[2] = '{8'd2, 8'd0, 8'h00};
    ce[3] = '{8'd0, 8'd1, 8'h78};
    ce[4] = '{8'd1, 8'd1, 8'h79};
    ce[5] = '{8'd2, 8'd1, 8'h00};
    ce[6] = '{8'd3, 8'd1, 8'h00};

    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.in_src     = 1'b0;
    bus.rd_col     = 8'd0;
    bus.rd_row     = 8'd0;
    bus.line_ready = 1'b0;

    // Reset values and initial full clear
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_rd_char", bus.rd_char, 0);
    chk("rst_rd_cursor", bus.rd_cursor, 0);
    chk("rst_line", {bus.line_valid, bus.line_last, bus.line_data}, 0);
    chk("rst_cursor", {bus.cur_col, bus.cur_row}, 0);
    rst_n = 1'b1;
    wait_ready(3000, cnt);
    chk("init_clear_cycles", cnt, 2100);

    for (int i = 0; i < 12; i++) begin
      send(cv[i].ch, 1'b0);
      chk($sformatf("cur_vec%0d", i), {bus.cur_col, bus.cur_row}, {cv[i].col, cv[i].row});
    end
    for (int i = 0; i < 7; i++) begin
      read_cell(ce[i].col, ce[i].row, v);
      chk($sformatf("cell_vec%0d", i), v, ce[i].val);
    end

    // Backspace at (3,4) and at column 0
    repeat (3) send(8'h0A, 1'b0);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h08, 1'b0);
    chk("bs_cursor", {bus.cur_col, bus.cur_row}, {8'd2, 8'd4});
    read_cell(2, 4, v);
    chk("bs_cell_cleared", v, 8'h00);
    read_cell(1, 4, v);
    chk("bs_cell_kept", v, 8'h62);
    send(8'h0D, 1'b0);
    send(8'h08, 1'b0);
    chk("bs_col0_cursor", {bus.cur_col, bus.cur_row}, {8'd0, 8'd4});
    read_cell(0, 4, v);
    chk("bs_col0_cell", v, 8'h61);

    // A full row of printables wraps without scrolling
    send(8'h0A, 1'b0);
    for (int i = 0; i < COLS; i++) send(8'(8'h30 + (i % 40)), 1'b0);
    chk("wrap_cursor", {bus.cur_col, bus.cur_row}, {8'd0, 8'd6});
    chk("wrap_no_clr_row", bus.in_ready, 1);
    read_cell(69, 5, v);
    chk("wrap_last_cell", v, 8'h4D);
    read_cell(0, 5, v);
    chk("wrap_first_cell", v, 8'h30);

    // Newline on the bottom row scrolls
    repeat (23) send(8'h0A, 1'b0);
    send(8'h68, 1'b0);
    send(8'h65, 1'b0);
    send(8'h6C, 1'b0);
    send(8'h6C, 1'b0);
    send(8'h6F, 1'b0);
    chk("pre_scroll_cursor", {bus.cur_col, bus.cur_row}, {8'd5, 8'd29});
    send(8'h0A, 1'b0);
    wait_ready(500, cnt);
    chk("clr_row_cycles", cnt, 70);
    chk("scroll_cursor", {bus.cur_col, bus.cur_row}, {8'd0, 8'd29});
    read_cell(0, 28, v);
    chk("scroll_row28_h", v, 8'h68);
    read_cell(4, 28, v);
    chk("scroll_row28_o", v, 8'h6F);
    read_cell(0, 0, v);
    chk("scroll_row0_was_row1", v, 8'h78);
    read_cell(0, 3, v);
    chk("scroll_row3_was_row4", v, 8'h61);
    nz = 0;
    for (int c = 0; c < COLS; c++) begin
      read_cell(c, 29, v);
      if (v != 8'h00) nz++;
    end
    chk("scroll_row29_blank", nz, 0);

    // Blink: half of 16 consecutive cycles on at the cursor, never elsewhere
    ones = 0;
    bus.rd_col = 8'd0;
    bus.rd_row = 8'd29;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.rd_cursor) ones++;
    end
    chk("blink_on_cursor", ones, 8);
    ones = 0;
    bus.rd_col = 8'd1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.rd_cursor) ones++;
    end
    chk("blink_off_cursor", ones, 0);

    // Form feed clears the whole screen
    send(8'h6B, 1'b0);
    send(8'h0C, 1'b0);
    chk("ff_cursor", {bus.cur_col, bus.cur_row}, 0);
    wait_ready(3000, cnt);
    chk("ff_clear_cycles", cnt, 2100);
    nz = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        read_cell(c, r, v);
        if (v != 8'h00) nz++;
      end
    end
    chk("ff_all_blank", nz, 0);

    // Reset in the middle of a clear restarts it from cell 0
    send(8'h41, 1'b0);
    send(8'h0C, 1'b0);
    repeat (500) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("midclr_rst_in_ready", bus.in_ready, 0);
    chk("midclr_rst_rd_char", bus.rd_char, 0);
    rst_n = 1'b1;
    wait_ready(3000, cnt);
    chk("midclr_restart_cycles", cnt, 2100);
    chk("midclr_cursor", {bus.cur_col, bus.cur_row}, 0);

`ifdef LINE_CAPTURE_EN
    send(8'h7A, 1'b0);
    send(8'h6C, 1'b1);
    send(8'h73, 1'b1);
    send(8'h0A, 1'b1);
    chk("cap_in_ready_low", bus.in_ready, 0);
    collect();
    chk("cap_beats", nb, 2);
    chk("cap_beat0", {bl[0], bd[0]}, {1'b0, 8'h6C});
    chk("cap_beat1", {bl[1], bd[1]}, {1'b1, 8'h73});
    chk("cap_done_ready", {bus.in_ready, bus.line_valid}, 2'b10);
    chk("cap_cursor", {bus.cur_col, bus.cur_row}, {8'd0, 8'd1});
    send(8'h0A, 1'b1);
    collect();
    chk("cap_empty_beats", nb, 1);
    chk("cap_empty_beat", {bl[0], bd[0]}, {1'b1, 8'h00});
`else
    send(8'h0A, 1'b1);
    chk("nocap_in_ready", bus.in_ready, 1);
    chk("nocap_line_tied", {bus.line_valid, bus.line_last, bus.line_data}, 0);
    chk("nocap_cursor", {bus.cur_col, bus.cur_row}, {8'd0, 8'd1});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
